ram_block_mover: RTL and testbench
==================================

Name: ram_block_mover

Overview:
- Initiator for the 512 x 16 RAM port (address, in, load, out); it drives the RAM's address/in/load pins and reads its out pin.
- Performs block copy (RAM to RAM) or block fill (constant to RAM) on a start pulse.
- Reports busy and done, and keeps a running 16-bit checksum of every word it writes.
- Sits between a controller or CPU and one RAM instance, replacing hand-driven bench stimulus of the RAM.

Parameters:
AW, 9, address width (512 words)
DW, 16, data width
CW, 10, count width (0..512 words)

Ports:
clk  input  1  system clock, rising edge active
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse, sampled only in IDLE
mode  input  1  0 = copy, 1 = fill; sampled with start
src_addr  input  AW  copy source base address
dst_addr  input  AW  destination base address
count  input  CW  number of words (0..512)
fill_val  input  DW  fill constant, sampled with start
mem_out  input  DW  RAM read data (RAM out pin)
mem_addr  output  AW  RAM address
mem_in  output  DW  RAM write data
mem_load  output  1  RAM write enable
busy  output  1  high from the cycle after start acceptance until done
done  output  1  one-cycle completion pulse
checksum  output  DW  sum mod 2^16 of words written in the current/last operation

Behaviour:
- One clock: clk. Reset is asynchronous and active-high: reset forces IDLE immediately, without waiting for a clock edge.
- Reset values: mem_addr=0, mem_in=0, mem_load=0, busy=0, done=0, checksum=0, index=0, data register=0.
- RAM contract:
  - Read is combinational: mem_out reflects mem_addr in the same cycle.
  - Write occurs at the rising edge when mem_load=1.
- Outputs are registered; state is Moore-encoded.
- States: IDLE, READ, WRITE, FIN.
- IDLE:
  - mem_load=0, busy=0.
  - On start=1 at a clock edge, latch mode, src_addr, dst_addr, count and fill_val; clear index and checksum.
  - Transitions: count=0 -> FIN. mode=0 -> READ. mode=1 -> WRITE.
- READ (copy only):
  - mem_addr = src + index, mem_load=0.
  - At the edge, capture mem_out into the data register. Next state WRITE.
- WRITE:
  - mem_addr = dst + index, mem_load=1.
  - mem_in = data register (copy) or fill_val (fill).
  - At the edge: checksum += mem_in (mod 2^16), index += 1.
  - If index = count-1 -> FIN. Otherwise copy -> READ, fill -> WRITE.
- FIN:
  - done=1 for exactly one cycle, mem_load=0, busy=0. Next state IDLE.
  - checksum holds its value until the next accepted start.
- Latency:
  - Copy of N words: busy for 2N cycles, done in cycle 2N+1 after acceptance.
  - Fill of N words: busy for N cycles, done in cycle N+1.
  - count=0: no writes, busy never asserts, done pulses the cycle after acceptance.
- Address arithmetic is mod 512: base+index wraps, e.g. dst=510 with count=4 writes 510, 511, 0, 1.
- Overlap: copy runs in strictly ascending index order with read-before-write per word. Overlapping regions with dst > src propagate already-copied data; this is the defined behaviour.
- start while busy or in FIN is ignored; there is no queueing.
- Inputs other than mem_out are don't-care after acceptance; changing them mid-operation has no effect.
- count > 512 is saturated to 512.
- Reset mid-operation:
  - mem_load deasserts asynchronously and no further writes occur.
  - done does not pulse.
  - The word being written at the reset edge is not guaranteed.

Test Plan:
- Reset then idle: assert reset at t=2 with no clock edge -> all outputs 0 immediately; 10 idle cycles -> mem_load never 1.
- Fill: mode=1, dst=100, count=4, fill_val=0x00AB -> addresses 100..103 hold 0x00AB; busy for 4 cycles; done on cycle 5; checksum=0x02AC.
- Copy: preload RAM[0..2] = 123, 246, 369; mode=0, src=0, dst=200, count=3 -> RAM[200..202] = 123, 246, 369; busy for 6 cycles; checksum=738; mem_load alternates 0,1.
- Wrap and zero count:
  - Fill with dst=510, count=4, fill_val=7 -> words 510, 511, 0, 1 = 7.
  - count=0 -> no write, done on the next cycle, checksum=0.
- Boundary and overflow: copy count=512 from src=0 to dst=0 over RAM filled with 0xFFFF -> RAM unchanged, 1024 busy cycles, checksum = 512*0xFFFF mod 2^16 = 0xFE00.
- Robustness:
  - start pulsed mid-copy -> ignored and parameters unchanged.
  - reset asserted during a WRITE cycle of a count=8 fill -> mem_load drops immediately, done never pulses, next start runs normally.

Source files
------------

// File: rtl/ram_block_mover.sv
// ram_block_mover: block copy / block fill engine for a single 512 x 16 RAM
// port with combinational read and write-on-rising-edge. All RAM-facing
// outputs and status flags are registered and derived from the next state.
module ram_block_mover #(
    parameter int AW = 9,   // address width
    parameter int DW = 16,  // data width
    parameter int CW = 10   // word-count width
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,      // 0 = copy, 1 = fill
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [CW-1:0] count,
    input  logic [DW-1:0] fill_val,
    input  logic [DW-1:0] mem_out,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_in,
    output logic          mem_load,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    // Largest transfer is the whole RAM; larger requests are clamped to it.
    localparam logic [CW-1:0] MAX_COUNT = CW'(1 << AW);
    localparam logic [CW-1:0] ONE       = CW'(1);

    // Control state
    state_t        state_q,    state_d;
    logic          mode_q,     mode_d;
    logic [AW-1:0] src_q,      src_d;
    logic [AW-1:0] dst_q,      dst_d;
    logic [CW-1:0] count_q,    count_d;
    logic [DW-1:0] fill_q,     fill_d;
    logic [CW-1:0] index_q,    index_d;
    logic [DW-1:0] data_q,     data_d;
    logic [DW-1:0] checksum_q, checksum_d;

    // Registered outputs
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_in_q,   mem_in_d;
    logic          mem_load_q, mem_load_d;
    logic          busy_q,     busy_d;
    logic          done_q,     done_d;

    logic [CW-1:0] count_sat;
    logic          last_word;

    // Clamp the requested count and flag the final word of the transfer.
    always_comb begin
        count_sat = (count > MAX_COUNT) ? MAX_COUNT : count;
        last_word = (index_q == count_q - ONE);
    end

    // Next-state, operand latching, checksum and registered-output values.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        mode_d     = mode_q;
        src_d      = src_q;
        dst_d      = dst_q;
        count_d    = count_q;
        fill_d     = fill_q;
        index_d    = index_q;
        data_d     = data_q;
        checksum_d = checksum_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d     = mode;
                    src_d      = src_addr;
                    dst_d      = dst_addr;
                    count_d    = count_sat;
                    fill_d     = fill_val;
                    index_d    = '0;
                    checksum_d = '0;
                    if (count_sat == '0) begin
                        state_d = S_FIN;
                    end else if (mode) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                // The RAM read is combinational, so mem_out already reflects
                // the source address presented during this cycle.
                data_d  = mem_out;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                checksum_d = checksum_q + mem_in_q;
                index_d    = index_q + ONE;
                if (last_word) begin
                    state_d = S_FIN;
                end else if (mode_q) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are a function of the state being entered, so they appear
        // registered in the same cycle as that state.
        mem_addr_d = mem_addr_q;
        mem_in_d   = mem_in_q;
        mem_load_d = (state_d == S_WRITE);
        busy_d     = (state_d == S_READ) || (state_d == S_WRITE);
        done_d     = (state_d == S_FIN);

        case (state_d)
            S_READ: begin
                mem_addr_d = src_d + index_d[AW-1:0];
            end
            S_WRITE: begin
                mem_addr_d = dst_d + index_d[AW-1:0];
                mem_in_d   = mode_d ? fill_d : data_d;
            end
            default: begin
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            count_q    <= '0;
            fill_q     <= '0;
            index_q    <= '0;
            data_q     <= '0;
            checksum_q <= '0;
            mem_addr_q <= '0;
            mem_in_q   <= '0;
            mem_load_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed before this edge, independent of statement order.
            state_q    <= state_d;
            mode_q     <= mode_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            count_q    <= count_d;
            fill_q     <= fill_d;
            index_q    <= index_d;
            data_q     <= data_d;
            checksum_q <= checksum_d;
            mem_addr_q <= mem_addr_d;
            mem_in_q   <= mem_in_d;
            mem_load_q <= mem_load_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_in   = mem_in_q;
    assign mem_load = mem_load_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign checksum = checksum_q;

endmodule

// File: tb/tb_ram_block_mover.sv
// Self-checking bench for ram_block_mover: a 512 x 16 RAM model, a table of
// directed operations, randomized operations and reset corner cases, all
// checked against a word-level reference of what each operation must do.
module tb_ram_block_mover;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int CW = 10;
    localparam int WORDS = 512;
    localparam int BUDGET = 1100;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [CW-1:0] count = '0;
    logic [DW-1:0] fill_val = '0;
    logic [DW-1:0] mem_out;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_in;
    logic          mem_load;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;

    logic [DW-1:0] ram   [WORDS];   // RAM seen by the DUT
    logic [DW-1:0] model [WORDS];   // expected RAM contents

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_block_mover #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .count    (count),
        .fill_val (fill_val),
        .mem_out  (mem_out),
        .mem_addr (mem_addr),
        .mem_in   (mem_in),
        .mem_load (mem_load),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    // RAM: combinational read, write on the rising edge when load is high.
    assign mem_out = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_load) ram[mem_addr] = mem_in;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_ram(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < WORDS; i++) begin
            if (ram[i] !== model[i]) bad++;
        end
        check(name, 32'(bad), 32'd0);
    endtask

    // Run one operation: the reference applies the copy/fill word by word in
    // ascending order, then the DUT is driven and watched cycle by cycle.
    task automatic run_op(input logic m, input int src, input int dst, input int cnt,
                          input logic [15:0] fv, input int glitch,
                          output int busy_cycles, output int done_cycle,
                          output logic [15:0] cs_seen);
        int            n;
        int            writes;
        int            exp_a [$];
        logic [15:0]   exp_w [$];
        logic [15:0]   sum;
        logic          exp_load;

        n   = (cnt > WORDS) ? WORDS : cnt;
        sum = 16'h0;
        for (int i = 0; i < n; i++) begin
            int          s;
            int          d;
            logic [15:0] v;
            s = (src + i) % WORDS;
            d = (dst + i) % WORDS;
            v = m ? fv : model[s];
            model[d] = v;
            exp_a.push_back(d);
            exp_w.push_back(v);
            sum = sum + v;
        end

        @(negedge clk);
        start    = 1'b1;
        mode     = m;
        src_addr = AW'(src);
        dst_addr = AW'(dst);
        count    = CW'(cnt);
        fill_val = fv;
        @(negedge clk);
        // Parameters are don't-care after acceptance: scramble them.
        start    = 1'b0;
        mode     = 1'($urandom);
        src_addr = AW'($urandom);
        dst_addr = AW'($urandom);
        count    = CW'($urandom);
        fill_val = DW'($urandom);

        busy_cycles = 0;
        done_cycle  = 0;
        writes      = 0;
        cs_seen     = 16'h0;
        for (int cyc = 1; cyc <= BUDGET && done_cycle == 0; cyc++) begin
            if (busy) busy_cycles++;
            exp_load = m ? (cyc <= n) : ((cyc <= 2 * n) && (cyc % 2 == 0));
            check("load_pattern", 32'(mem_load), 32'(exp_load));
            if (mem_load) begin
                if (writes < n) begin
                    check("write_addr", 32'(mem_addr), 32'(exp_a[writes]));
                    check("write_data", 32'(mem_in), 32'(exp_w[writes]));
                end
                writes++;
            end
            if (done) begin
                done_cycle = cyc;
                cs_seen    = checksum;
            end
            if (cyc == glitch) begin
                start    = 1'b1;
                mode     = ~m;
                count    = CW'(5);
                src_addr = AW'($urandom);
                dst_addr = AW'($urandom);
            end else begin
                start = 1'b0;
            end
            if (done_cycle == 0) @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", 32'(done_cycle != 0), 32'd1);
        check("write_count", 32'(writes), 32'(n));
        check("checksum_model", 32'(cs_seen), 32'(sum));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_not_busy", 32'(busy), 32'd0);
        check("checksum_hold", 32'(checksum), 32'(sum));
        check_ram("ram_contents");
    endtask

    typedef struct {
        logic        m;
        int          src;
        int          dst;
        int          cnt;
        logic [15:0] fill;
        int          preload;   // 0 none, 1 words 0..2, 2 all 0xFFFF, 3 random
        int          exp_busy;
        int          exp_done;
        int          exp_cs;    // -1: checked against the reference only
        int          glitch;    // cycle of a stray start pulse, 0 = none
    } vec_t;

    vec_t vecs [9];

    task automatic preload(input int kind);
        logic [15:0] v;
        for (int i = 0; i < WORDS; i++) begin
            case (kind)
                1:       v = (i < 3) ? 16'(123 * (i + 1)) : ram[i];
                2:       v = 16'hFFFF;
                3:       v = 16'($urandom);
                default: v = ram[i];
            endcase
            ram[i]   = v;
            model[i] = v;
        end
    endtask

    initial begin
        int          bc;
        int          dc;
        logic [15:0] cs;

        for (int i = 0; i < WORDS; i++) begin
            ram[i]   = 16'h0;
            model[i] = 16'h0;
        end

        // Asynchronous reset with no clock edge yet (first edge at t=5).
        #2 reset = 1'b1;
        #1;
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_in",   32'(mem_in),   32'd0);
        check("rst_mem_load", 32'(mem_load), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_no_load", 32'(mem_load), 32'd0);
        end

        vecs[0] = '{1'b1,   0, 100,   4, 16'h00AB, 0,    4,    5, 32'h02AC, 0};
        vecs[1] = '{1'b0,   0, 200,   3, 16'h0000, 1,    6,    7, 738,      0};
        vecs[2] = '{1'b1,   0, 510,   4, 16'h0007, 0,    4,    5, 28,       0};
        vecs[3] = '{1'b1,   0,  50,   0, 16'h5555, 0,    0,    1, 0,        0};
        vecs[4] = '{1'b0,  20,  60,   0, 16'h0000, 0,    0,    1, 0,        0};
        vecs[5] = '{1'b0,   0,   0, 512, 16'h0000, 2, 1024, 1025, 32'hFE00, 0};
        vecs[6] = '{1'b1,   0,  37, 700, 16'h0001, 0,  512,  513, 32'h0200, 0};
        vecs[7] = '{1'b0,  10,  12,   6, 16'h0000, 3,   12,   13, -1,       5};
        vecs[8] = '{1'b0, 300, 100,   8, 16'h0000, 0,   16,   17, -1,       3};

        for (int k = 0; k < 9; k++) begin
            preload(vecs[k].preload);
            run_op(vecs[k].m, vecs[k].src, vecs[k].dst, vecs[k].cnt, vecs[k].fill,
                   vecs[k].glitch, bc, dc, cs);
            check("busy_cycles", 32'(bc), 32'(vecs[k].exp_busy));
            check("done_cycle",  32'(dc), 32'(vecs[k].exp_done));
            if (vecs[k].exp_cs >= 0) check("checksum", 32'(cs), 32'(vecs[k].exp_cs));
        end

        // Randomized operations against the reference.
        for (int k = 0; k < 20; k++) begin
            logic m;
            int   n;
            m = 1'($urandom);
            n = int'($urandom_range(0, 40));
            run_op(m, int'($urandom_range(0, WORDS - 1)), int'($urandom_range(0, WORDS - 1)),
                   n, 16'($urandom), (n > 2) ? 2 : 0, bc, dc, cs);
            check("rand_busy_cycles", 32'(bc), 32'(m ? n : 2 * n));
            check("rand_done_cycle",  32'(dc), 32'((m ? n : 2 * n) + 1));
        end

        // Reset during a WRITE cycle of an 8-word fill at 300.
        @(negedge clk);
        start    = 1'b1;
        mode     = 1'b1;
        dst_addr = AW'(300);
        count    = CW'(8);
        fill_val = 16'h1234;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_pre_load", 32'(mem_load), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_load_drop", 32'(mem_load), 32'd0);
        check("mid_rst_busy_drop", 32'(busy), 32'd0);
        // Two edges completed before reset; the third word is not guaranteed.
        model[300] = 16'h1234;
        model[301] = 16'h1234;
        model[302] = ram[302];
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (done || mem_load) seen++;
            end
            check("mid_rst_quiet", 32'(seen), 32'd0);
        end
        check_ram("mid_rst_ram");

        // Next operation after the aborted one runs normally.
        run_op(1'b0, 300, 400, 5, 16'h0, 0, bc, dc, cs);
        check("post_rst_busy", 32'(bc), 32'd10);
        check("post_rst_done", 32'(dc), 32'd11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
